ps2_receiver: RTL and testbench

Receives PS/2 device-to-host frames on the raw `ps2_clk`/`ps2_data` pins and delivers each decoded byte as a one-cycle strobe to the keyboard scan-code decoder. Sits directly between the board pins and the keyboard decoder, which consumes `data`/`valid`. The block synchronises and deglitches the asynchronous PS/2 lines, deframes 11-bit frames, checks parity and framing, and recovers from truncated frames by timeout.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_filter.sv | 49 ++++
 rtl/ps2_receiver.sv | 164 ++++++++++++++++
 tb/tb_ps2_receiver.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types, frame constants and parity helper for the
//               PS/2 device-to-host receiver.
// Revision    : 1.0
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    // Parity bit value that makes the total count of ones (data + parity) odd.
    function automatic logic ps2_odd_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~(^d);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_filter
// Description : 2-FF synchroniser plus FILTER_LEN-sample debounce for one
//               asynchronous line; output resets high (idle level).
// Revision    : 1.0
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_level
);

    localparam int c_CNT_W = $clog2(FILTER_LEN + 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;

    // The counter tracks how long the synchronised line has disagreed with
    // the filtered level; any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_W'(FILTER_LEN - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ps2_receiver
// Description : PS/2 device-to-host frame receiver with parity/stop checks
//               and a mid-frame watchdog.
// Revision    : 1.0
// ============================================================================
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       error
);

    localparam int c_WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_BIT_W = $clog2(PS2_FRAME_BITS);

    ps2_state_t                 r_state;
    ps2_state_t                 w_next_state;
    logic                       w_fclk;
    logic                       r_data_s1;
    logic                       r_data_s2;
    logic                       r_fclk_d;
    logic                       r_fall;
    logic                       r_fall_data;
    logic [PS2_DATA_BITS-1:0]   r_shreg;
    logic [c_BIT_W-1:0]         r_bit_cnt;
    logic                       r_parity;
    logic [c_WD_W-1:0]          r_wd;
    logic [7:0]                 r_data;
    logic                       r_valid;
    logic                       r_error;
    logic                       w_start;
    logic                       w_shift;
    logic                       w_cap_par;
    logic                       w_valid_nxt;
    logic                       w_error_nxt;
    logic                       w_timeout;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk     (clk),
        .reset   (reset),
        .i_line  (ps2_clk),
        .o_level (w_fclk)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_cap_par    = 1'b0;
        w_valid_nxt  = 1'b0;
        w_error_nxt  = 1'b0;
        // Fires one cycle early so the registered error lines up with the
        // cycle in which the watchdog reads TIMEOUT_CYCLES.
        w_timeout    = (r_state != IDLE) && !r_fall &&
                       (r_wd == c_WD_W'(TIMEOUT_CYCLES - 1));
        case (r_state)
            IDLE: begin
                if (r_fall && !r_fall_data) begin
                    w_next_state = DATA;
                    w_start      = 1'b1;
                end
            end
            DATA: begin
                if (r_fall) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == c_BIT_W'(PS2_DATA_BITS - 1)) begin
                        w_next_state = PARITY;
                    end
                end
            end
            PARITY: begin
                if (r_fall) begin
                    w_cap_par    = 1'b1;
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (r_fall) begin
                    if ((r_parity == ps2_odd_parity(r_shreg)) && r_fall_data) begin
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_error_nxt = 1'b1;
                    end
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (w_timeout) begin
            w_next_state = IDLE;
            w_error_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_s1   <= 1'b1;
            r_data_s2   <= 1'b1;
            r_fclk_d    <= 1'b1;
            r_fall      <= 1'b0;
            r_fall_data <= 1'b1;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_parity    <= 1'b0;
            r_wd        <= '0;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_data_s1   <= ps2_data;
            r_data_s2   <= r_data_s1;
            r_fclk_d    <= w_fclk;
            r_fall      <= r_fclk_d & ~w_fclk;
            r_fall_data <= r_data_s2;
            if (w_start) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
            end
            if (w_shift) begin
                r_shreg <= {r_fall_data, r_shreg[PS2_DATA_BITS-1:1]};
            end
            if (w_cap_par) begin
                r_parity <= r_fall_data;
            end
            if ((r_state == IDLE) || r_fall) begin
                r_wd <= '0;
            end else begin
                r_wd <= r_wd + c_WD_W'(1);
            end
            r_valid <= w_valid_nxt;
            r_error <= w_error_nxt;
            if (w_valid_nxt) begin
                r_data <= r_shreg;
            end
        end
    end

    assign data  = r_data;
    assign valid = r_valid;
    assign error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_receiver
// Description : Self-checking bench: directed and random PS/2 frames against
//               a frame-level reference model.
// Revision    : 1.0
// ============================================================================
module tb_ps2_receiver;

    localparam int F    = 8;
    localparam int T    = 2000;
    localparam int HALF = 40;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       error;

    ps2_receiver #(
        .FILTER_LEN     (F),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data     (data),
        .valid    (valid),
        .error    (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_valid = 0;
    int         n_error = 0;
    int         n_both  = 0;
    int         err_cyc = 0;
    logic [7:0] obs_q[$];

    always @(posedge clk) begin
        #1;
        if (valid) begin
            n_valid++;
            obs_q.push_back(data);
        end
        if (error) begin
            n_error++;
            err_cyc = cyc;
        end
        if (valid && error) n_both++;
    end

    // Reference model state
    int         checks    = 0;
    int         errors    = 0;
    int         exp_valid = 0;
    int         exp_error = 0;
    logic [7:0] model_data = 8'h00;
    logic [7:0] exp_q[$];
    int         last_low = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk  = 1'b0;
        last_low = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk  = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(~bad_stop);
        @(negedge clk);
        ps2_data = 1'b1;
        if (!bad_par && !bad_stop) begin
            exp_valid++;
            exp_q.push_back(b);
            model_data = b;
        end else begin
            exp_error++;
        end
    endtask

    task automatic settle_and_check(input string tag);
        repeat (F + 20) @(negedge clk);
        check({tag, " valid count"}, n_valid, exp_valid);
        check({tag, " error count"}, n_error, exp_error);
        check({tag, " data"}, {24'h0, data}, {24'h0, model_data});
        check({tag, " queue depth"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            check({tag, " byte order"}, {24'h0, obs_q.pop_front()}, {24'h0, exp_q.pop_front()});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int delta;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset data", {24'h0, data}, 32'h0);
        check("reset valid", {31'h0, valid}, 32'h0);
        check("reset error", {31'h0, error}, 32'h0);

        send_frame(8'h1D, 1'b0, 1'b0);
        settle_and_check("scan 1D");

        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        settle_and_check("back-to-back F0 22");

        send_frame(8'h41, 1'b1, 1'b0);
        settle_and_check("bad parity 41");

        send_frame(8'h5A, 1'b0, 1'b1);
        settle_and_check("bad stop");
        send_frame(8'h4C, 1'b0, 1'b0);
        settle_and_check("after bad stop 4C");

        // Truncated frame: start plus four data bits, then idle lines.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        @(negedge clk);
        ps2_data = 1'b1;
        exp_error++;
        repeat (T + F + 40) @(negedge clk);
        delta = err_cyc - last_low;
        check("timeout latency window",
              {31'h0, (delta >= T + F + 2) && (delta <= T + F + 6)}, 32'h1);
        settle_and_check("timeout");
        send_frame(8'h32, 1'b0, 1'b0);
        settle_and_check("after timeout 32");

        // Glitch narrower than the filter
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        settle_and_check("clk glitch");

        // Reset in the middle of a frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        @(negedge clk);
        ps2_data = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_data = 8'h00;
        settle_and_check("mid-frame reset");

        for (int k = 0; k < 8; k++) begin
            logic [7:0] b;
            logic       bp;
            logic       bs;
            b  = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 4) == 0);
            send_frame(b, bp, bs);
            settle_and_check("random frame");
        end

        check("valid and error overlap", n_both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
